fifo_reader: RTL and testbench

Read-side controller that drains the synchronous `fifo` block and presents its contents as a valid/ready stream. Drives the FIFO's read enable, absorbs its one-cycle registered read latency in a 2-entry skid buffer, and sustains one word per clock under continuous downstream readiness. Sits between a `fifo` instance and any Abies stream consumer (DSP pipeline, DAC/codec serializer).

---
 rtl/fifo_reader.sv | 120 ++++++++++++
 tb/tb_fifo_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side controller draining a synchronous FIFO into a valid/ready stream
//
// Issues FIFO reads against a 2-entry credit so the FIFO's one-cycle read
// latency is absorbed without bubbles; one word per clock when the consumer
// is always ready.
//
// Ports:
//   clk        in   single rising-edge clock
//   rst        in   asynchronous active-low reset (0 = reset)
//   o_rd       out  FIFO read enable (to FIFO i_rd)
//   i_rdata    in   FIFO read data, valid the cycle after o_rd
//   i_rempty   in   FIFO empty flag, 1 blocks new reads
//   i_flush    in   synchronous discard of buffered and in-flight words
//   o_data     out  stream data (skid buffer head)
//   o_valid    out  stream valid
//   i_ready    in   stream ready from consumer
//   o_word_cnt out  delivered-word counter, only when FIFO_READER_CNT_EN is defined
//
// Build option: define FIFO_READER_CNT_EN to add the o_word_cnt port and counter.

module fifo_reader #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_rd,
    input  logic [DW-1:0] i_rdata,
    input  logic          i_rempty,
    input  logic          i_flush,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]   o_word_cnt
`endif
);

    logic [1:0]    count_q, count_d;
    logic          inflight_q;
    logic          flush_prev_q;
    logic          head_q, head_d;
    logic          tail_q, tail_d;
    logic [DW-1:0] buf0_q, buf1_q;

    logic          pop;
    logic          capture;
    logic [2:0]    occ_after_pop;

    assign o_valid = (count_q != 2'd0);
    assign o_data  = head_q ? buf1_q : buf0_q;
    assign pop     = o_valid & i_ready;

    // Occupancy once this cycle's pop leaves, counting the word already
    // requested last cycle; a new read is only issued if it will have a slot.
    assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign o_rd = rst & ~i_rempty & ~i_flush & (occ_after_pop < 3'd2);

    // A returning word is dropped if a flush is active now or was last cycle.
    assign capture = inflight_q & ~flush_prev_q & ~i_flush;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (i_flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end
            if (capture) begin
                tail_d = ~tail_q;
            end
            count_d = count_q + {1'b0, capture} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            flush_prev_q <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            buf0_q       <= '0;
            buf1_q       <= '0;
        end else begin
            count_q      <= count_d;
            inflight_q   <= o_rd;
            flush_prev_q <= i_flush;
            head_q       <= head_d;
            tail_q       <= tail_d;
            if (capture && !tail_q) begin
                buf0_q <= i_rdata;
            end
            if (capture && tail_q) begin
                buf1_q <= i_rdata;
            end
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [15:0] word_cnt_q;

    // Counts every handshake, including one in a flush cycle; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q <= 16'd0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign o_word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - randomized and directed bench for fifo_reader with a queue-based reference model

module tb_fifo_reader;

    localparam int DW = 24;

    logic          clk;
    logic          rst;
    logic          o_rd;
    logic [DW-1:0] i_rdata;
    logic          i_rempty;
    logic          i_flush;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
`ifdef FIFO_READER_CNT_EN
    logic [15:0]   o_word_cnt;
`endif

    fifo_reader #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .o_rd       (o_rd),
        .i_rdata    (i_rdata),
        .i_rempty   (i_rempty),
        .i_flush    (i_flush),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
`ifdef FIFO_READER_CNT_EN
        ,
        .o_word_cnt (o_word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Source FIFO contents and the reference model of what the reader holds.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] held[$];
    logic [DW-1:0] got[$];
    int            hs_cyc[$];
    logic          inflight_m;
    logic          flush_prev_m;
    logic [15:0]   wcnt_m;
    int            cyc;
    int            first_rd;
    int            first_valid;
    logic          last_rd;
    logic          last_valid;
    logic [DW-1:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: called at posedge+1, returns at next posedge+1.
    task automatic cycle(input logic rdy, input logic fl);
        logic [DW-1:0] rword;
        logic          exp_valid;
        logic          pop;
        logic          exp_rd;
        logic          cap;
        int            occ;
        rword = DW'($urandom);
        if (inflight_m && fifo_q.size() > 0) rword = fifo_q.pop_front();
        i_rdata  = rword;
        i_ready  = rdy;
        i_flush  = fl;
        i_rempty = (fifo_q.size() == 0);
        @(negedge clk);
        exp_valid = (held.size() != 0);
        pop       = exp_valid && rdy;
        occ       = held.size() + int'(inflight_m) - int'(pop);
        exp_rd    = !i_rempty && !fl && (occ < 2);
        check("o_valid", 32'(o_valid), 32'(exp_valid));
        check("o_rd", 32'(o_rd), 32'(exp_rd));
        if (exp_valid) check("o_data", 32'(o_data), 32'(held[0]));
`ifdef FIFO_READER_CNT_EN
        check("o_word_cnt", 32'(o_word_cnt), 32'(wcnt_m));
`endif
        last_rd    = o_rd;
        last_valid = o_valid;
        last_data  = o_data;
        if (o_rd && first_rd < 0) first_rd = cyc;
        if (o_valid && first_valid < 0) first_valid = cyc;
        if (o_valid && rdy) begin
            got.push_back(o_data);
            hs_cyc.push_back(cyc);
        end
        cap = inflight_m && !flush_prev_m && !fl;
        if (cap && !pop && held.size() == 2) begin
            miscompares++;
            $display("FAIL skid_overflow: capture with 2 held and no pop (cycle %0d)", cyc);
        end
        if (fl) begin
            held.delete();
        end else begin
            if (pop) void'(held.pop_front());
            if (cap) held.push_back(rword);
        end
        if (pop) wcnt_m = wcnt_m + 16'd1;
        inflight_m   = exp_rd;
        flush_prev_m = fl;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_rd", 32'(o_rd), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        held.delete();
        fifo_q.delete();
        inflight_m   = 1'b0;
        flush_prev_m = 1'b0;
        wcnt_m       = 16'd0;
        i_flush      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        got.delete();
        hs_cyc.delete();
        cyc         = 0;
        first_rd    = -1;
        first_valid = -1;
    endtask

    task automatic load(input int first, input int n);
        for (int k = 0; k < n; k++) fifo_q.push_back(DW'(first + k));
    endtask

    task automatic check_seq(input string name, input int first, input int n);
        check({name, "_len"}, 32'(got.size()), 32'(n));
        for (int k = 0; k < n && k < got.size(); k++)
            check(name, 32'(got[k]), 32'(first + k));
    endtask

    initial begin
        rst      = 1'b0;
        i_rdata  = '0;
        i_rempty = 1'b0;
        i_flush  = 1'b0;
        i_ready  = 1'b1;
        inflight_m   = 1'b0;
        flush_prev_m = 1'b0;
        wcnt_m       = 16'd0;
        cyc = 0;
        first_rd = -1;
        first_valid = -1;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state, with a non-empty FIFO so o_rd gating is exercised.
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_o_rd", 32'(o_rd), 32'd0);
        check("reset_o_data", 32'(o_data), 32'd0);

        // Preloaded 1..4, consumer always ready: back-to-back delivery.
        do_reset();
        load(1, 4);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0);
        check("t1_first_rd", 32'(first_rd), 32'd0);
        check("t1_first_valid", 32'(first_valid), 32'd2);
        check_seq("t1_data", 1, 4);
        for (int k = 0; k < 4 && k < hs_cyc.size(); k++)
            check("t1_hs_cycle", 32'(hs_cyc[k]), 32'(2 + k));

        // Five-cycle stall mid-burst: two words held, reads stopped.
        do_reset();
        load(1, 8);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0);
        check("t2_stall_rd", 32'(last_rd), 32'd0);
        check("t2_stall_valid", 32'(last_valid), 32'd1);
        check("t2_stall_data", 32'(last_data), 32'd3);
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0);
        check_seq("t2_data", 1, 8);

        // Ready toggling every cycle.
        do_reset();
        load(1, 8);
        for (int k = 0; k < 24; k++) cycle(k % 2 == 0, 1'b0);
        check_seq("t3_data", 1, 8);

        // Flush with one word held and one returning from the FIFO.
        do_reset();
        load(1, 10);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        check("t4_valid_after_flush", 32'(last_valid), 32'd0);
        for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0);
        check("t4_len", 32'(got.size()), 32'd8);
        if (got.size() > 0) check("t4_data0", 32'(got[0]), 32'd1);
        for (int k = 1; k < 8 && k < got.size(); k++)
            check("t4_data", 32'(got[k]), 32'(k + 3));

        // Asynchronous reset mid-burst, then fresh restart.
        do_reset();
        load(1, 6);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
        check("t5_valid_before_rst", 32'(last_valid), 32'd1);
        do_reset();
        load(32'h100, 4);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0);
        check_seq("t5_data", 32'h100, 4);

        // Randomized traffic, ready and flush against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) fifo_q.push_back(DW'($urandom));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

`ifdef FIFO_READER_CNT_EN
        // Delivered-word counter wrap.
        do_reset();
        begin
            bit seen_ffff = 0, seen_0 = 0, seen_1 = 0;
            for (int k = 0; k < 70000 && !seen_1; k++) begin
                while (fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
                cycle(1'b1, 1'b0);
                if (got.size() == 65535 && !seen_ffff) begin
                    check("cnt_ffff", 32'(o_word_cnt), 32'hFFFF);
                    seen_ffff = 1;
                end
                if (got.size() == 65536 && !seen_0) begin
                    check("cnt_wrap0", 32'(o_word_cnt), 32'h0000);
                    seen_0 = 1;
                end
                if (got.size() == 65537) begin
                    check("cnt_wrap1", 32'(o_word_cnt), 32'h0001);
                    seen_1 = 1;
                end
            end
            if (!seen_1) begin
                miscompares++;
                $display("FAIL cnt_timeout: only %0d handshakes seen", got.size());
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
